// File: rtl/vga_rx_if.sv
// vga_rx_if: VGA pin bundle in, recovered pixel stream and status out.
// Latency: none; plain wires between the source and the receiver.
// Backpressure: none; VGA timing is free-running on both sides.
interface vga_rx_if #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int COLORS      = 3,
  parameter int COLOR_DEPTH = 8
);
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  // Pin side
  logic [COLOR_DEPTH-1:0]        vga_r;
  logic [COLOR_DEPTH-1:0]        vga_g;
  logic [COLOR_DEPTH-1:0]        vga_b;
  logic                          vga_hsync;
  logic                          vga_vsync;

  // Recovered stream and status
  logic [COLORS*COLOR_DEPTH-1:0] pixel_data;
  logic                          pixel_valid;
  logic [XW-1:0]                 pix_x;
  logic [YW-1:0]                 pix_y;
  logic                          line_start;
  logic                          frame_start;
  logic                          locked;
  logic                          sync_error;
  logic                          blank_error;

  // Source / capture side: drives the pins, observes the recovered stream
  modport master (
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
    input  pixel_data, pixel_valid, pix_x, pix_y,
    input  line_start, frame_start, locked, sync_error, blank_error
  );

  // Receiver side
  modport slave (
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
    output pixel_data, pixel_valid, pix_x, pix_y,
    output line_start, frame_start, locked, sync_error, blank_error
  );
endinterface

// File: rtl/vga_rx.sv
// vga_rx: VGA receiver that recovers x/y from active-low sync edges and checks timing.
// Latency: pins -> outputs 2 clocks (S1 input register, then output register).
// Backpressure: none; one pixel per clock, the stream never stalls.
// Optional: define VGA_RX_BLANK_CHECK_EN to flag nonzero colour outside the active area.
module vga_rx #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 525,
  parameter int COLORS      = 3,
  parameter int COLOR_DEPTH = 8
) (
  input  logic    clk_25mhz,
  input  logic    rst_n,
  vga_rx_if.slave vga
);

  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int CW = COLORS * COLOR_DEPTH;

  // Sync edge positions on the recovered raster
  localparam logic [XW-1:0] HS_FALL_X = XW'(H_DISPLAY + H_FRONT);
  localparam logic [XW-1:0] HS_RISE_X = XW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [XW-1:0] X_LAST    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT     = XW'(H_DISPLAY);
  localparam logic [YW-1:0] VS_FALL_Y = YW'(V_DISPLAY + V_FRONT);
  localparam logic [YW-1:0] VS_RISE_Y = YW'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT     = YW'(V_DISPLAY);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // S1 sample of the pins plus the previous S1 syncs for edge detection
  logic [CW-1:0] s1_rgb;
  logic          s1_hsync;
  logic          s1_vsync;
  logic          hsync_prev;
  logic          vsync_prev;
  logic          hs_fall;
  logic          hs_rise;
  logic          vs_fall;
  logic          vs_rise;

  // Position of the previous S1 sample, and of the current one
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [XW-1:0] x_pred;
  logic [XW-1:0] x_new;
  logic [YW-1:0] y_inc;
  logic [YW-1:0] y_new;
  logic          timing_bad;

  // Next values of the registered outputs
  logic          locked_nxt;
  logic          active_nxt;
  logic          valid_nxt;
  logic          line_nxt;
  logic          frame_nxt;
  logic          err_nxt;

  logic [CW-1:0] data_q;
  logic          valid_q;
  logic          line_q;
  logic          frame_q;
  logic          locked_q;
  logic          err_q;

  // Capture the pins; syncs idle high in reset so release shows no edge
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb     <= '0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
      hsync_prev <= 1'b1;
      vsync_prev <= 1'b1;
    end else begin
      s1_rgb     <= {vga.vga_r, vga.vga_g, vga.vga_b};
      s1_hsync   <= vga.vga_hsync;
      s1_vsync   <= vga.vga_vsync;
      hsync_prev <= s1_hsync;
      vsync_prev <= s1_vsync;
    end
  end

  assign hs_fall = hsync_prev & ~s1_hsync;
  assign hs_rise = ~hsync_prev & s1_hsync;
  assign vs_fall = vsync_prev & ~s1_vsync;
  assign vs_rise = ~vsync_prev & s1_vsync;

  // Position of the S1 sample: free-running prediction, hsync fall reloads x,
  // and in TRACK a vsync fall at x==0 reloads y. hsync load is applied first,
  // so a coincident vsync fall sees x!=0 and is ignored.
  always_comb begin
    x_pred = (x_cnt == X_LAST) ? '0 : x_cnt + 1'b1;
    y_inc  = (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
    x_new  = hs_fall ? HS_FALL_X : x_pred;
    if (state == TRACK && vs_fall && x_new == '0) begin
      y_new = VS_FALL_Y;
    end else if (x_new == '0) begin
      y_new = y_inc;
    end else begin
      y_new = y_cnt;
    end
  end

  // Any sync edge off its predicted position, or a missing hsync fall.
  // y_inc is the predicted line whenever x_pred is 0.
  always_comb begin
    timing_bad = (hs_fall != (x_pred == HS_FALL_X))
              || (hs_rise && x_pred != HS_RISE_X)
              || (vs_fall && !(x_pred == '0 && y_inc == VS_FALL_Y))
              || (vs_rise && !(x_pred == '0 && y_inc == VS_RISE_Y));
  end

  // State register
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: hsync fall gets us tracking, an aligned vsync fall locks,
  // any timing violation while locked drops back to search
  always_comb begin
    state_nxt = state;
    unique case (state)
      SEARCH: if (hs_fall) state_nxt = TRACK;
      TRACK:  if (vs_fall && x_new == '0) state_nxt = LOCKED;
      LOCKED: if (timing_bad) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // Output decode for the S1 sample, registered below alongside its pixel
  always_comb begin
    locked_nxt = (state_nxt == LOCKED);
    active_nxt = (x_new < X_ACT) && (y_new < Y_ACT);
    valid_nxt  = locked_nxt && active_nxt;
    line_nxt   = valid_nxt && (x_new == '0);
    frame_nxt  = line_nxt && (y_new == '0);
    err_nxt    = (state == LOCKED) && timing_bad;
  end

  // Output register stage and position counters
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      x_cnt    <= x_new;
      y_cnt    <= y_new;
      data_q   <= s1_rgb;
      valid_q  <= valid_nxt;
      line_q   <= line_nxt;
      frame_q  <= frame_nxt;
      locked_q <= locked_nxt;
      err_q    <= err_nxt;
    end
  end

  assign vga.pixel_data  = data_q;
  assign vga.pixel_valid = valid_q;
  assign vga.pix_x       = x_cnt;
  assign vga.pix_y       = y_cnt;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;
  assign vga.locked      = locked_q;
  assign vga.sync_error  = err_q;

`ifdef VGA_RX_BLANK_CHECK_EN
  logic blank_q;

  // Flag colour driven during blanking while locked; lock is not affected
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= locked_nxt && !active_nxt && (|s1_rgb);
    end
  end

  assign vga.blank_error = blank_q;
`else
  assign vga.blank_error = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed bench for vga_rx on a reduced 40x20 raster.
// Latency: expects outputs two clocks after the pins.
// Backpressure: none; the source advances one pixel every clock.
module tb_vga_rx;

  // Reduced timing keeps whole frames short: 16x12 active, 40x20 total
  localparam int HD = 16, HF = 4, HSW = 8, HT = 40;
  localparam int VD = 12, VF = 2, VSW = 2, VT = 20;
  localparam int HS_X   = HD + HF;         // 20
  localparam int HS_END = HD + HF + HSW;   // 28
  localparam int VS_Y   = VD + VF;         // 14
  localparam int VS_END = VD + VF + VSW;   // 16
  localparam int FRAME  = HT * VT;         // 800
  localparam int BP_X   = 24;              // inside the hsync pulse, blanked

  logic clk_25mhz = 1'b0;
  logic rst_n;

  always #20 clk_25mhz = ~clk_25mhz;

  vga_rx_if #(.H_TOTAL(HT), .V_TOTAL(VT), .COLORS(3), .COLOR_DEPTH(8)) vif();

  vga_rx #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_TOTAL(VT),
    .COLORS(3), .COLOR_DEPTH(8)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .rst_n(rst_n),
    .vga(vif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Source position to drive next, the two previous driven positions,
  // and the position the outputs currently describe
  int gx, gy, px, py, ppx, ppy, ox, oy;
  int early_line = -1;
  int short_line = -1;
  int poke_line  = -1;
  int cnt_valid, cnt_line, cnt_frame, cnt_err, cnt_locked;
  logic exp_blank;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (obs x=%0d y=%0d)", tag, got, exp, ox, oy);
    end
  endtask

  task automatic clr_counts();
    cnt_valid = 0; cnt_line = 0; cnt_frame = 0; cnt_err = 0; cnt_locked = 0;
  endtask

  // One clock: observe outputs at the falling edge, then drive the next pixel
  task automatic step();
    logic hs, vs;
    logic [7:0] r, g, b;
    @(negedge clk_25mhz);
    ox = ppx;
    oy = ppy;
    if (vif.pixel_valid) cnt_valid++;
    if (vif.line_start)  cnt_line++;
    if (vif.frame_start) cnt_frame++;
    if (vif.sync_error)  cnt_err++;
    if (vif.locked)      cnt_locked++;

    hs = !(gx >= HS_X && gx < HS_END);
    if (gy == early_line && gx == HS_X - 1)   hs = 1'b0;
    if (gy == short_line && gx == HS_END - 1) hs = 1'b1;
    vs = !(gy >= VS_Y && gy < VS_END);
    if (gx < HD && gy < VD) begin
      r = gx[7:0]; g = gy[7:0]; b = 8'hA5;
    end else begin
      r = 8'h00; g = 8'h00; b = 8'h00;
    end
    if (gy == poke_line && gx == BP_X) r = 8'h01;
    vif.vga_r = r;
    vif.vga_g = g;
    vif.vga_b = b;
    vif.vga_hsync = hs;
    vif.vga_vsync = vs;

    ppx = px; ppy = py;
    px  = gx; py  = gy;
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy++;
      if (gy == VT) gy = 0;
    end
  endtask

  // Run until the outputs describe source pixel (x,y); mode 1 checks pix_x, 2 both
  task automatic run_to(input int x, input int y, input int mode);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(ox == x && oy == y) && n < 2 * FRAME);
    if (!(ox == x && oy == y)) chk("run_to_budget", 32'(ox), 32'(x));
    if (mode >= 1) chk("pos_x", 32'(vif.pix_x), 32'(x));
    if (mode == 2) chk("pos_y", 32'(vif.pix_y), 32'(y));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 32'(vif.pixel_data), 32'h0);
    chk({tag, "_flags"}, 32'({vif.pixel_valid, vif.line_start, vif.frame_start,
                              vif.locked, vif.sync_error, vif.blank_error}), 32'h0);
    chk({tag, "_pos"}, 32'({vif.pix_x, vif.pix_y}), 32'h0);
  endtask

  initial begin
`ifdef VGA_RX_BLANK_CHECK_EN
    exp_blank = 1'b1;
`else
    exp_blank = 1'b0;
`endif
    rst_n = 1'b0;
    gx = 0; gy = VD;
    px = -1; py = -1; ppx = -1; ppy = -1; ox = -1; oy = -1;
    vif.vga_r = 8'h00; vif.vga_g = 8'h00; vif.vga_b = 8'h00;
    vif.vga_hsync = 1'b1; vif.vga_vsync = 1'b1;
    clr_counts();

    // Reset state
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Acquire: hsync fall in line 12, vsync fall at (0,14) locks
    run_to(HT - 1, VS_Y - 1, 1);
    chk("pre_lock", 32'(vif.locked), 32'h0);
    step();
    chk("lock_at_vs", 32'(vif.locked), 32'h1);
    chk("lock_y", 32'(vif.pix_y), 32'(VS_Y));

    // Spot checks in the first locked frame
    run_to(0, 0, 2);
    chk("p00_frame", 32'(vif.frame_start), 32'h1);
    chk("p00_line", 32'(vif.line_start), 32'h1);
    chk("p00_valid", 32'(vif.pixel_valid), 32'h1);
    chk("p00_data", 32'(vif.pixel_data), 32'h0000A5);
    run_to(HD, 0, 2);
    chk("x_edge_valid", 32'(vif.pixel_valid), 32'h0);
    run_to(HD - 1, VD - 1, 2);
    chk("last_valid", 32'(vif.pixel_valid), 32'h1);
    chk("last_data", 32'(vif.pixel_data), 32'h0F0BA5);
    run_to(0, VD, 2);
    chk("y_edge_line", 32'(vif.line_start), 32'h0);
    chk("y_edge_valid", 32'(vif.pixel_valid), 32'h0);
    chk("y_edge_locked", 32'(vif.locked), 32'h1);

    // One full locked frame
    run_to(0, 0, 2);
    clr_counts();
    repeat (FRAME) step();
    chk("frame_valid_cnt", 32'(cnt_valid), 32'd192);
    chk("frame_line_cnt", 32'(cnt_line), 32'd12);
    chk("frame_start_cnt", 32'(cnt_frame), 32'd1);
    chk("frame_err_cnt", 32'(cnt_err), 32'd0);

    // hsync falls one clock early on line 5
    early_line = 5;
    run_to(HS_X - 1, 5, 0);
    early_line = -1;
    chk("early_err", 32'(vif.sync_error), 32'h1);
    chk("early_locked", 32'(vif.locked), 32'h0);
    chk("early_valid", 32'(vif.pixel_valid), 32'h0);
    chk("early_x_load", 32'(vif.pix_x), 32'(HS_X));
    step();
    chk("early_err_pulse", 32'(vif.sync_error), 32'h0);
    clr_counts();
    run_to(HT - 1, VS_Y - 1, 1);
    chk("early_no_valid", 32'(cnt_valid), 32'd0);
    chk("early_no_lock", 32'(cnt_locked), 32'd0);
    step();
    chk("early_relock", 32'(vif.locked), 32'h1);

    // hsync low one clock short on line 3
    short_line = 3;
    run_to(HS_END - 1, 3, 2);
    short_line = -1;
    chk("short_err", 32'(vif.sync_error), 32'h1);
    chk("short_locked", 32'(vif.locked), 32'h0);
    run_to(0, 4, 2);
    chk("short_search", 32'(vif.locked), 32'h0);
    chk("short_err_pulse", 32'(vif.sync_error), 32'h0);
    run_to(0, VS_Y, 2);
    chk("short_relock", 32'(vif.locked), 32'h1);

    // Asynchronous reset mid-frame, between clock edges
    run_to(10, 6, 2);
    chk("pre_rst_valid", 32'(vif.pixel_valid), 32'h1);
    #5 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    step();
    step();
    rst_n = 1'b1;
    clr_counts();
    run_to(HT - 1, VS_Y - 1, 1);
    chk("rst_no_valid", 32'(cnt_valid), 32'd0);
    step();
    chk("rst_relock", 32'(vif.locked), 32'h1);
    run_to(0, 0, 2);
    chk("rst_frame", 32'(vif.frame_start), 32'h1);
    chk("rst_data", 32'(vif.pixel_data), 32'h0000A5);

    // Colour in blanking on a locked line
    poke_line = 2;
    run_to(BP_X - 1, 2, 2);
    chk("blank_before", 32'(vif.blank_error), 32'h0);
    step();
    poke_line = -1;
    chk("blank_hit", 32'(vif.blank_error), 32'(exp_blank));
    chk("blank_x", 32'(vif.pix_x), 32'(BP_X));
    chk("blank_locked", 32'(vif.locked), 32'h1);
    step();
    chk("blank_after", 32'(vif.blank_error), 32'h0);
    chk("blank_no_err", 32'(vif.sync_error), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
